prog_thresh_fifo: RTL and testbench

Synchronous single-clock FIFO that succeeds the team's fixed-threshold FIFO. It supports any integer depth, run-time programmable almost-full and almost-empty thresholds, an occupancy count output, and sticky overflow/underflow error flags. A parameter selects either a registered read port or a show-ahead read port. It sits between producer and consumer stages in the same clock domain, as a drop-in buffer with richer status.

---
 rtl/prog_thresh_fifo.sv | 108 ++++++++++
 tb/tb_prog_thresh_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/prog_thresh_fifo.sv
// Single-clock FIFO with any-integer depth, live-programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and selectable read port.
module prog_thresh_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int RD_MODE = 0,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  input  logic [CNT_W-1:0]  i_afull_th,
  input  logic [CNT_W-1:0]  i_aempty_th,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_alm_full,
  output logic              o_empty,
  output logic              o_alm_empty,
  input  logic              i_err_clr,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrptr;
  logic [PTR_W-1:0]  rdptr;
  logic [CNT_W-1:0]  count;
  logic              rd_acc;
  logic              wr_acc;

  assign o_count     = count;
  assign o_full      = (count == CNT_W'(DEPTH));
  assign o_empty     = (count == '0);
  assign o_alm_full  = (count >= i_afull_th);
  assign o_alm_empty = (count <= i_aempty_th);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = i_rden & ~o_empty;
  assign wr_acc = i_wren & (~o_full | rd_acc);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wrptr <= ptr_next(wrptr);
      if (rd_acc) rdptr <= ptr_next(rdptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wrptr] <= i_wrdata;
  end

  // Set wins over a coincident clear so no error event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wren && !wr_acc) o_overflow <= 1'b1;
      else if (i_err_clr)    o_overflow <= 1'b0;
      if (i_rden && !rd_acc) o_underflow <= 1'b1;
      else if (i_err_clr)    o_underflow <= 1'b0;
    end
  end

  generate
    if (RD_MODE == 0) begin : g_reg_rd
      logic [DATA_W-1:0] rddata_p1;
      logic              vld_p1;

      // Read stage p1: head entry captured on accept, valid for one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          rddata_p1 <= '0;
          vld_p1    <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rddata_p1 <= mem[rdptr];
        end
      end

      assign o_rddata  = rddata_p1;
      assign o_rdvalid = vld_p1;
    end else begin : g_show_ahead
      assign o_rddata  = mem[rdptr];
      assign o_rdvalid = ~o_empty;
    end
  endgenerate

endmodule

// File: tb/tb_prog_thresh_fifo.sv
// Randomized and directed bench for prog_thresh_fifo, both read modes side by side,
// checked against a queue-based reference model.
module tb_prog_thresh_fifo;

  localparam int DW = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst, wren, rden, err_clr;
  logic [DW-1:0] wrdata;
  logic [CW-1:0] afull_th, aempty_th;

  logic [DW-1:0] rddata0, rddata1;
  logic          rdvalid0, rdvalid1;
  logic [CW-1:0] count0, count1;
  logic          full0, full1, afull0, afull1, empty0, empty1, aempty0, aempty1;
  logic          ovf0, ovf1, udf0, udf1;

  int checks   = 0;
  int failures = 0;

  int q[$];
  bit m_ovf, m_udf, m_vld0;
  int m_data0;

  always #5 clk = ~clk;

  prog_thresh_fifo #(.DATA_W(DW), .DEPTH(D), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .o_rddata(rddata0), .o_rdvalid(rdvalid0), .i_afull_th(afull_th),
    .i_aempty_th(aempty_th), .o_count(count0), .o_full(full0), .o_alm_full(afull0),
    .o_empty(empty0), .o_alm_empty(aempty0), .i_err_clr(err_clr),
    .o_overflow(ovf0), .o_underflow(udf0)
  );

  prog_thresh_fifo #(.DATA_W(DW), .DEPTH(D), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .o_rddata(rddata1), .o_rdvalid(rdvalid1), .i_afull_th(afull_th),
    .i_aempty_th(aempty_th), .o_count(count1), .o_full(full1), .o_alm_full(afull1),
    .o_empty(empty1), .o_alm_empty(aempty1), .i_err_clr(err_clr),
    .o_overflow(ovf1), .o_underflow(udf1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check_val({tag, " count0"},   32'(count0),   32'(n));
    check_val({tag, " count1"},   32'(count1),   32'(n));
    check_val({tag, " full0"},    32'(full0),    32'(n == D));
    check_val({tag, " full1"},    32'(full1),    32'(n == D));
    check_val({tag, " empty0"},   32'(empty0),   32'(n == 0));
    check_val({tag, " empty1"},   32'(empty1),   32'(n == 0));
    check_val({tag, " afull0"},   32'(afull0),   32'(n >= int'(afull_th)));
    check_val({tag, " afull1"},   32'(afull1),   32'(n >= int'(afull_th)));
    check_val({tag, " aempty0"},  32'(aempty0),  32'(n <= int'(aempty_th)));
    check_val({tag, " aempty1"},  32'(aempty1),  32'(n <= int'(aempty_th)));
    check_val({tag, " ovf0"},     32'(ovf0),     32'(m_ovf));
    check_val({tag, " ovf1"},     32'(ovf1),     32'(m_ovf));
    check_val({tag, " udf0"},     32'(udf0),     32'(m_udf));
    check_val({tag, " udf1"},     32'(udf1),     32'(m_udf));
    check_val({tag, " rdvalid0"}, 32'(rdvalid0), 32'(m_vld0));
    check_val({tag, " rddata0"},  32'(rddata0),  32'(m_data0));
    check_val({tag, " rdvalid1"}, 32'(rdvalid1), 32'(n != 0));
    if (n != 0) check_val({tag, " rddata1"}, 32'(rddata1), 32'(q[0]));
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare after the edge.
  task automatic step(input string tag, input bit we, input logic [DW-1:0] wd,
                      input bit re, input bit clr, input bit r);
    bit ra, wa;
    wren = we; wrdata = wd; rden = re; err_clr = clr; rst = r;
    if (r) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_vld0 = 0; m_data0 = 0;
    end else begin
      ra = re && (q.size() != 0);
      wa = we && ((q.size() < D) || ra);
      m_vld0 = ra;
      if (ra) m_data0 = q.pop_front();
      if (wa) q.push_back(int'(wd));
      if (we && !wa) m_ovf = 1; else if (clr) m_ovf = 0;
      if (re && !ra) m_udf = 1; else if (clr) m_udf = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b0; err_clr = 1'b0; wrdata = '0;
    afull_th = '0; aempty_th = 3'd1;

    step("reset_a", 1, 8'h11, 1, 0, 1);
    step("reset_b", 1, 8'h22, 1, 0, 1);
    afull_th = 3'd4;

    for (int i = 0; i < 5; i++) step("fill", 1, 8'hA0 + 8'(i), 0, 0, 0);
    step("overflow", 1, 8'hEE, 0, 0, 0);

    for (int i = 0; i < 5; i++) step("drain", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step("wrap_wr", 1, 8'hB0 + 8'(i), 0, 0, 0);
      step("wrap_rd", 0, 8'h00, 1, 0, 0);
    end
    step("idle", 0, 8'h00, 0, 0, 0);
    step("underflow", 0, 8'h00, 1, 0, 0);
    step("err_clr", 0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 5; i++) step("fill2", 1, 8'hC0 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step("full_rw", 1, 8'hD0 + 8'(i), 1, 0, 0);
    for (int i = 0; i < 5; i++) step("drain2", 0, 8'h00, 1, 0, 0);
    step("empty_rw", 1, 8'h5A, 1, 0, 0);
    step("empty_rw_next", 0, 8'h00, 0, 0, 0);

    afull_th = 3'd3; aempty_th = 3'd1;
    step("th_reset", 0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("th_fill", 1, 8'h60 + 8'(i), 0, 0, 0);
    afull_th = 3'd5;
    #1;
    check_all("th_live");

    step("e_drain", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("e_drain", 0, 8'h00, 1, 0, 0);
    step("e_udf", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("e_fill", 1, 8'h70 + 8'(i), 0, 0, 0);
    step("e_ovf", 1, 8'h7F, 0, 0, 0);
    step("e_clr_ovf", 1, 8'h7E, 0, 1, 0);
    step("e_clr", 0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 2; i++) step("e_half", 0, 8'h00, 1, 0, 0);
    step("mid_reset", 1, 8'h99, 1, 0, 1);
    step("post_reset", 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      afull_th  = CW'($urandom_range(0, 7));
      aempty_th = CW'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 9) < 6), DW'($urandom),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
